// File: rtl/rsa_exp_engine.sv
// Modular exponentiation engine: plain_text^exponent mod modulus by left-to-right
// square-and-multiply, each modular multiply done bit-serially (add/shift/reduce).
module rsa_exp_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en_rsa,
  input  logic             rst_rsa,
  input  logic [WIDTH-1:0] plain_text,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             eoc,
  output logic [WIDTH-1:0] encrypted_text
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = WIDTH + 2;
  localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_SQUARE,
    S_MULT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [PW-1:0]    p_q, p_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] enc_q, enc_d;

  // Shared datapath: REDUCE feeds one dividend bit (A is the dividend shift register),
  // SQUARE/MULT feed R when the scanned multiplier bit is set. Sum stays below 3M.
  logic          mul_bit;
  logic [PW-1:0] addend, sum, m_ext, red1, red2;

  always_comb begin
    mul_bit = (state_q == S_MULT) ? a_q[cnt_q] : r_q[cnt_q];
    addend  = '0;
    case (state_q)
      S_REDUCE:       addend = PW'(a_q[WIDTH-1]);
      S_SQUARE,
      S_MULT:         addend = mul_bit ? {2'b00, r_q} : '0;
      default:        addend = '0;
    endcase
    m_ext = {2'b00, m_q};
    sum   = (p_q << 1) + addend;
    red1  = (sum  >= m_ext) ? sum  - m_ext : sum;
    red2  = (red1 >= m_ext) ? red1 - m_ext : red1;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    r_d     = r_q;
    m_d     = m_q;
    e_d     = e_q;
    p_d     = p_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    enc_d   = enc_q;
    if (!rst_rsa) begin
      state_d = S_IDLE;
    end else if (en_rsa) begin
      case (state_q)
        S_IDLE: begin
          m_d   = modulus;
          e_d   = exponent;
          a_d   = plain_text;
          p_d   = '0;
          cnt_d = CNT_MAX;
          if (modulus[WIDTH-1:1] == '0) begin
            state_d = S_DONE;
            r_d     = '0;
            enc_d   = '0;
          end else begin
            state_d = S_REDUCE;
          end
        end
        S_REDUCE: begin
          p_d = red2;
          a_d = {a_q[WIDTH-2:0], 1'b0};
          if (cnt_q == '0) begin
            a_d     = red2[WIDTH-1:0];
            r_d     = ONE;
            p_d     = '0;
            bit_d   = CNT_MAX;
            cnt_d   = CNT_MAX;
            state_d = S_SQUARE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_SQUARE, S_MULT: begin
          p_d = red2;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            r_d   = red2[WIDTH-1:0];
            p_d   = '0;
            cnt_d = CNT_MAX;
            if (state_q == S_SQUARE && e_q[bit_q]) begin
              state_d = S_MULT;
            end else if (bit_q == '0) begin
              state_d = S_DONE;
              enc_d   = red2[WIDTH-1:0];
            end else begin
              bit_d   = bit_q - CNT_ONE;
              state_d = S_SQUARE;
            end
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      r_q     <= '0;
      m_q     <= '0;
      e_q     <= '0;
      p_q     <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      enc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      r_q     <= r_d;
      m_q     <= m_d;
      e_q     <= e_d;
      p_q     <= p_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      enc_q   <= enc_d;
    end
  end

  assign eoc            = (state_q == S_DONE);
  assign encrypted_text = enc_q;

endmodule

// File: tb/tb_rsa_exp_engine.sv
// Directed + random bench for rsa_exp_engine against an arithmetic modexp model.
module tb_rsa_exp_engine;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstb, en_rsa, rst_rsa, eoc;
  logic [W-1:0] plain_text, exponent, modulus, encrypted_text;
  int           checks = 0;
  int           errors = 0;
  int           last_res = 0;

  always #5 clk = ~clk;

  rsa_exp_engine #(.WIDTH(W)) dut (
    .clk(clk), .rstb(rstb), .en_rsa(en_rsa), .rst_rsa(rst_rsa),
    .plain_text(plain_text), .exponent(exponent), .modulus(modulus),
    .eoc(eoc), .encrypted_text(encrypted_text)
  );

  function automatic int modexp(input int p, input int e, input int m);
    longint r, b;
    if (m < 2) return 0;
    r = 1;
    b = p % m;
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % m;
      if (((e >> i) & 1) == 1) r = (r * b) % m;
    end
    return int'(r);
  endfunction

  function automatic int latency(input int e, input int m);
    if (m < 2) return 1;
    return 1 + W + W * (W + $countones(e[W-1:0]));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start(input int p, input int e, input int m);
    @(negedge clk);
    plain_text = W'(p); exponent = W'(e); modulus = W'(m);
    en_rsa = 1'b1; rst_rsa = 1'b0;
    @(negedge clk);
    rst_rsa = 1'b1;
  endtask

  // Counts edges until eoc; inputs are scrambled after the start edge, stalls inserted.
  task automatic wait_done(input int stalls, input int limit, output int edges);
    int sleft;
    edges = 0;
    sleft = stalls;
    do begin
      if (edges > 0) begin
        plain_text = W'($urandom); exponent = W'($urandom); modulus = W'($urandom);
      end
      if (sleft > 0 && edges >= 10 && ($urandom_range(0, 1) == 1 || (60 - edges) <= sleft)) begin
        en_rsa = 1'b0;
        sleft--;
      end else begin
        en_rsa = 1'b1;
      end
      @(negedge clk);
      edges++;
      if (!en_rsa) check("stall_eoc", 32'(eoc), 0);
    end while (!eoc && edges < limit);
    en_rsa = 1'b1;
  endtask

  task automatic run(input string tag, input int p, input int e, input int m, input int stalls);
    int edges, exp_res;
    exp_res = modexp(p, e, m);
    start(p, e, m);
    wait_done(stalls, 400, edges);
    check({tag, "_lat"}, 32'(edges), 32'(latency(e, m) + stalls));
    check({tag, "_eoc"}, 32'(eoc), 1);
    check({tag, "_res"}, 32'(encrypted_text), 32'(exp_res));
    last_res = exp_res;
  endtask

  initial begin
    rstb = 1'b0; en_rsa = 1'b0; rst_rsa = 1'b0;
    plain_text = '0; exponent = '0; modulus = '0;
    repeat (2) @(negedge clk);
    check("reset_eoc", 32'(eoc), 0);
    check("reset_enc", 32'(encrypted_text), 0);
    rstb = 1'b1;

    run("t88_7", 88, 7, 187, 0);
    check("t88_7_val", 32'(encrypted_text), 11);
    repeat (5) begin
      @(negedge clk);
      check("done_hold_eoc", 32'(eoc), 1);
      check("done_hold_enc", 32'(encrypted_text), 11);
    end
    rst_rsa = 1'b0;
    @(negedge clk);
    check("eoc_fall", 32'(eoc), 0);
    check("enc_keep", 32'(encrypted_text), 11);

    run("t11_23", 11, 23, 187, 0);
    check("t11_23_val", 32'(encrypted_text), 88);
    run("tff_1", 255, 1, 187, 0);
    check("tff_1_val", 32'(encrypted_text), 68);
    run("exp0", int'($urandom_range(0, 255)), 0, 187, 0);
    check("exp0_val", 32'(encrypted_text), 1);
    run("mod1", 88, 7, 1, 0);
    check("mod1_val", 32'(encrypted_text), 0);
    run("mod0", 88, 7, 0, 0);

    run("stall", 88, 7, 187, 10);
    check("stall_val", 32'(encrypted_text), 11);

    // soft reset with en_rsa low still returns to IDLE
    @(negedge clk);
    en_rsa = 1'b0; rst_rsa = 1'b0;
    @(negedge clk);
    check("softrst_noen_eoc", 32'(eoc), 0);
    check("softrst_noen_enc", 32'(encrypted_text), 11);
    en_rsa = 1'b1;

    run("pre_abort", 200, 13, 251, 0);
    start(88, 7, 187);
    repeat (49) @(negedge clk);
    check("abort_pre_eoc", 32'(eoc), 0);
    rst_rsa = 1'b0;
    @(negedge clk);
    check("abort_eoc", 32'(eoc), 0);
    check("abort_enc", 32'(encrypted_text), 32'(last_res));
    repeat (3) @(negedge clk);
    check("abort_hold_eoc", 32'(eoc), 0);
    run("restart", 11, 23, 187, 0);

    start(88, 7, 187);
    repeat (30) @(negedge clk);
    rstb = 1'b0; rst_rsa = 1'b0;
    @(negedge clk);
    check("rstb_mid_eoc", 32'(eoc), 0);
    check("rstb_mid_enc", 32'(encrypted_text), 0);
    rstb = 1'b1;

    run("pre_rstb", 88, 7, 187, 0);
    rstb = 1'b0;
    @(negedge clk);
    check("rstb_done_eoc", 32'(eoc), 0);
    check("rstb_done_enc", 32'(encrypted_text), 0);
    rstb = 1'b1;

    for (int k = 0; k < 8; k++) begin
      run("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 255)), (k % 2 == 1) ? 4 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rsa_exp_engine.md
# rsa_exp_engine

Modular exponentiation engine that sits on the rsa_unit side of the RSA enable/reset/end-of-conversion handshake. It computes encrypted_text = plain_text^exponent mod modulus using left-to-right square-and-multiply. Each modular multiply is a bit-serial interleaved add/shift/reduce. The engine is driven by the RSA enable controller through en_rsa and rst_rsa, and returns eoc to it.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2).

- clk  input  1  system clock; all logic on rising edge.
- rstb  input  1  reset, synchronous, active-low.
- en_rsa  input  1  clock enable; when low, all state and outputs freeze.
- rst_rsa  input  1  soft reset, active-low; low forces IDLE. A rising level (with en_rsa=1) starts a conversion.
- plain_text  input  WIDTH  message operand; sampled at start.
- exponent  input  WIDTH  exponent; sampled at start.
- modulus  input  WIDTH  modulus; sampled at start.
- eoc  output  1  end of conversion; level, high only in DONE.
- encrypted_text  output  WIDTH  result register.

## Operation
- Priority: rstb > rst_rsa > en_rsa.
- rstb=0 at edge: state=IDLE, eoc=0, encrypted_text=0, and all internal registers cleared.
- rst_rsa=0 at edge, independent of en_rsa: state=IDLE, eoc=0. encrypted_text keeps its last value.
- en_rsa=0 with rst_rsa=1: no register changes.
- Internal registers:
  - A, R, M, E: WIDTH bits each.
  - P: WIDTH+2 bits.
  - bit index: clog2(WIDTH) bits.
  - iteration counter: clog2(WIDTH) bits.
- States:
  - IDLE: when rst_rsa=1 and en_rsa=1, capture M=modulus, E=exponent and load the divider with plain_text. If M<2, go to DONE with R=0. Otherwise go to REDUCE with remainder=0 and counter=WIDTH-1.
  - REDUCE: restoring division, one bit per cycle, MSB first. rem = {rem,plain_bit}; if rem ≥ M, rem -= M. After WIDTH cycles: A=rem (plain_text mod M), R=1, bit index=WIDTH-1, P=0, go to SQUARE.
  - SQUARE: computes R·R mod M over WIDTH cycles, scanning multiplier bits i=WIDTH-1..0.
    - Each cycle: P' = 2P + (R[i] ? R : 0), then subtract M up to twice until P' < M.
    - Last cycle: R=P'. If E[bit index]=1, go to MULT (P=0). Otherwise advance the bit.
  - MULT: same datapath computing R·A mod M over WIDTH cycles, scanning multiplier bits of A. Last cycle: R=P', then advance the bit.
  - Advance bit: if bit index=0, go to DONE and latch encrypted_text=R. Otherwise decrement bit index, P=0, go to SQUARE.
  - DONE: eoc=1, encrypted_text stable. Stays in DONE until rst_rsa=0. A new start requires rst_rsa low for at least one edge.
- Arithmetic:
  - The invariant P,R,A < M holds, so 2P+addend < 3M fits in WIDTH+2 bits. Reduction is two conditional subtracts in one combinational cycle.
  - Exponent 0 yields R=1 (M ≥ 2).
  - M<2 yields 0.
  - plain_text ≥ M is handled by REDUCE.
- Input changes after the start edge are ignored.

## Timing
- Edge 1 = IDLE edge that accepts the start.
- The full conversion, with pop = popcount(exponent), is:
  - 1 start edge + WIDTH REDUCE edges + WIDTH·(WIDTH + WIDTH·pop/WIDTH)… i.e. 1 + WIDTH + WIDTH·(WIDTH + pop) enabled edges.
  - The DONE entry is the last of these edges. eoc goes high and encrypted_text updates on that same edge.
- M<2: DONE entered on edge 1, with eoc=1 and encrypted_text=0 after edge 1.
- Each cycle with en_rsa=0 adds one cycle of latency. Nothing advances during such a cycle.
- eoc falls on the first edge sampling rst_rsa=0.
- rst_rsa=0 mid-computation: IDLE at the next edge, eoc stays 0, and the partial result is discarded (encrypted_text unchanged).
- rstb=0 mid-computation: full clear at the next edge.

## Test plan
- WIDTH=8, plain=88, exponent=7, modulus=187, then rst_rsa rises with en_rsa=1: encrypted_text=11 and eoc=1 after 97 edges. eoc holds until rst_rsa=0, then clears on the next edge.
- plain=11, exponent=23, modulus=187: encrypted_text=88 with eoc after 105 edges. Follow with plain=0xFF, exponent=1, modulus=187: result 68.
- exponent=0, modulus=187 → result 1. Then modulus=1 → result 0 with eoc after 1 edge.
- Run the 88/7/187 case with en_rsa low for 10 random cycles mid-run: same result 11, eoc delayed to edge 107, and no state change during stalls.
- Drop rst_rsa at edge 50 of a run: IDLE next edge, eoc stays 0, encrypted_text keeps its prior value. Then restart: correct result at the nominal latency.
- Assert rstb=0 mid-run and during DONE: eoc=0 and encrypted_text=0 after the edge. Inputs changed after the start edge do not affect the result.
